// File: rtl/batalha_naval_pkg.sv
// Shared constants, fleet table and placement-sequencer state encoding for Batalha Naval.
package batalha_naval_pkg;

    localparam int NUM_NAVIOS     = 11;
    localparam int TIMEOUT_CICLOS = 64;

    localparam logic [2:0] TIPO_PORTA_AVIOES = 3'd0;
    localparam logic [2:0] TIPO_ENCOURACADO  = 3'd1;
    localparam logic [2:0] TIPO_CRUZADOR     = 3'd2;
    localparam logic [2:0] TIPO_SUBMARINO    = 3'd3;

    typedef enum logic [2:0] {
        OCIOSO,
        ESPERA,
        LIBERA,
        VALIDA,
        RESULTADO,
        TROCA,
        CONCLUIDO
    } estado_posic_t;

    // Fleet order: 1 carrier, 2 battleships, 3 cruisers, 5 submarines.
    function automatic logic [2:0] tipo_do_navio(input logic [3:0] indice);
        if (indice == 4'd0) begin
            return TIPO_PORTA_AVIOES;
        end else if (indice <= 4'd2) begin
            return TIPO_ENCOURACADO;
        end else if (indice <= 4'd5) begin
            return TIPO_CRUZADOR;
        end else begin
            return TIPO_SUBMARINO;
        end
    endfunction

endpackage

// File: rtl/controlador_posicionamento_if.sv
// Handshake bundle between the placement sequencer (master) and the placement validator (slave).
interface controlador_posicionamento_if;

    logic       val_enable;
    logic [2:0] val_tipo;
    logic [3:0] val_x1;
    logic [3:0] val_y1;
    logic       val_direcao;
    logic [2:0] val_orientacao;
    logic       val_jogador;
    logic       val_ready;
    logic       val_conflito;
    logic       val_conflitoBorda;
    logic       val_conflitoMemoria;

    modport master (
        output val_enable, val_tipo, val_x1, val_y1, val_direcao, val_orientacao, val_jogador,
        input  val_ready, val_conflito, val_conflitoBorda, val_conflitoMemoria
    );

    modport slave (
        input  val_enable, val_tipo, val_x1, val_y1, val_direcao, val_orientacao, val_jogador,
        output val_ready, val_conflito, val_conflitoBorda, val_conflitoMemoria
    );

endinterface

// File: rtl/watchdog_validador.sv
// Validator watchdog: cleared by carrega_i, counts while conta_i, flags LIMITE cycles.
// Built only when VALIDADOR_WATCHDOG_EN is defined.
`ifdef VALIDADOR_WATCHDOG_EN
module watchdog_validador #(
    parameter int LIMITE = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic carrega_i,
    input  logic conta_i,
    output logic expirou_o
);

    localparam int W = $clog2(LIMITE);

    logic [W-1:0] contagem_q;
    logic [W-1:0] contagem_d;

    assign expirou_o = (contagem_q == W'(LIMITE - 1));

    always_comb begin
        contagem_d = contagem_q;
        if (carrega_i) begin
            contagem_d = '0;
        end else if (conta_i && !expirou_o) begin
            contagem_d = contagem_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            contagem_q <= '0;
        end else begin
            contagem_q <= contagem_d;
        end
    end

endmodule
`endif

// File: rtl/controlador_posicionamento.sv
// Ship-placement sequencer for Batalha Naval: walks both fleets, drives the validator, reports results.
// Optional validator watchdog enabled by defining VALIDADOR_WATCHDOG_EN.
module controlador_posicionamento
    import batalha_naval_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                iniciar_i,
    input  logic                                confirma_i,
    input  logic [3:0]                          x_i,
    input  logic [3:0]                          y_i,
    input  logic                                direcao_i,
    input  logic [2:0]                          orientacao_i,
    controlador_posicionamento_if.master         val_if,
    output logic [3:0]                          indice_navio_o,
    output logic                                aceito_o,
    output logic                                erro_borda_o,
    output logic                                erro_memoria_o,
    output logic                                ocupado_o,
    output logic                                fase_concluida_o,
    output logic                                erro_timeout_o
);

    localparam logic [3:0] ULTIMO_NAVIO = 4'(NUM_NAVIOS - 1);

    estado_posic_t estado_q, estado_d;
    logic [3:0]    indice_q, indice_d;
    logic          jogador_q, jogador_d;
    logic [3:0]    x_q, x_d, y_q, y_d;
    logic          direcao_q, direcao_d;
    logic [2:0]    orientacao_q, orientacao_d;
    logic [2:0]    tipo_q, tipo_d;
    logic          enable_q, enable_d;
    logic          conflito_q, conflito_d;
    logic          borda_q, borda_d;
    logic          memoria_q, memoria_d;
    logic          aceito_q, aceito_d;
    logic          erro_borda_q, erro_borda_d;
    logic          erro_memoria_q, erro_memoria_d;
    logic          ocupado_q, ocupado_d;
    logic          concluida_q, concluida_d;

`ifdef VALIDADOR_WATCHDOG_EN
    logic expirou;
    logic timeout_q, timeout_d;

    // Counter is cleared on the same edge that launches the validator.
    watchdog_validador #(
        .LIMITE(TIMEOUT_CICLOS)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .carrega_i (estado_q == LIBERA && !val_if.val_ready),
        .conta_i   (estado_q == VALIDA),
        .expirou_o (expirou)
    );
`endif

    always_comb begin
        estado_d       = estado_q;
        indice_d       = indice_q;
        jogador_d      = jogador_q;
        x_d            = x_q;
        y_d            = y_q;
        direcao_d      = direcao_q;
        orientacao_d   = orientacao_q;
        enable_d       = enable_q;
        conflito_d     = conflito_q;
        borda_d        = borda_q;
        memoria_d      = memoria_q;
        aceito_d       = 1'b0;
        erro_borda_d   = 1'b0;
        erro_memoria_d = 1'b0;
`ifdef VALIDADOR_WATCHDOG_EN
        timeout_d      = 1'b0;
`endif

        case (estado_q)
            OCIOSO: begin
                if (iniciar_i) begin
                    estado_d = ESPERA;
                end
            end
            ESPERA: begin
                if (confirma_i) begin
                    x_d          = x_i;
                    y_d          = y_i;
                    direcao_d    = direcao_i;
                    orientacao_d = orientacao_i;
                    estado_d     = LIBERA;
                end
            end
            LIBERA: begin
                // A ready left high from the previous check must clear before launching.
                if (!val_if.val_ready) begin
                    enable_d = 1'b1;
                    estado_d = VALIDA;
                end
            end
            VALIDA: begin
                if (val_if.val_ready) begin
                    enable_d   = 1'b0;
                    conflito_d = val_if.val_conflito;
                    borda_d    = val_if.val_conflitoBorda;
                    memoria_d  = val_if.val_conflitoMemoria;
                    estado_d   = RESULTADO;
                end
`ifdef VALIDADOR_WATCHDOG_EN
                else if (expirou) begin
                    enable_d  = 1'b0;
                    timeout_d = 1'b1;
                    estado_d  = ESPERA;
                end
`endif
            end
            RESULTADO: begin
                if (conflito_q) begin
                    erro_borda_d   = borda_q;
                    erro_memoria_d = memoria_q;
                    estado_d       = ESPERA;
                end else begin
                    aceito_d = 1'b1;
                    if (indice_q < ULTIMO_NAVIO) begin
                        indice_d = indice_q + 4'd1;
                        estado_d = ESPERA;
                    end else begin
                        estado_d = TROCA;
                    end
                end
            end
            TROCA: begin
                if (!jogador_q) begin
                    jogador_d = 1'b1;
                    indice_d  = 4'd0;
                    estado_d  = ESPERA;
                end else begin
                    estado_d = CONCLUIDO;
                end
            end
            CONCLUIDO: begin
                if (iniciar_i) begin
                    indice_d  = 4'd0;
                    jogador_d = 1'b0;
                    estado_d  = ESPERA;
                end
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase

        ocupado_d   = (estado_d != OCIOSO) && (estado_d != CONCLUIDO);
        concluida_d = (estado_d == CONCLUIDO);
        tipo_d      = tipo_do_navio(indice_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q       <= OCIOSO;
            indice_q       <= 4'd0;
            jogador_q      <= 1'b0;
            x_q            <= 4'd0;
            y_q            <= 4'd0;
            direcao_q      <= 1'b0;
            orientacao_q   <= 3'd0;
            tipo_q         <= 3'd0;
            enable_q       <= 1'b0;
            conflito_q     <= 1'b0;
            borda_q        <= 1'b0;
            memoria_q      <= 1'b0;
            aceito_q       <= 1'b0;
            erro_borda_q   <= 1'b0;
            erro_memoria_q <= 1'b0;
            ocupado_q      <= 1'b0;
            concluida_q    <= 1'b0;
        end else begin
            estado_q       <= estado_d;
            indice_q       <= indice_d;
            jogador_q      <= jogador_d;
            x_q            <= x_d;
            y_q            <= y_d;
            direcao_q      <= direcao_d;
            orientacao_q   <= orientacao_d;
            tipo_q         <= tipo_d;
            enable_q       <= enable_d;
            conflito_q     <= conflito_d;
            borda_q        <= borda_d;
            memoria_q      <= memoria_d;
            aceito_q       <= aceito_d;
            erro_borda_q   <= erro_borda_d;
            erro_memoria_q <= erro_memoria_d;
            ocupado_q      <= ocupado_d;
            concluida_q    <= concluida_d;
        end
    end

`ifdef VALIDADOR_WATCHDOG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign erro_timeout_o = timeout_q;
`else
    assign erro_timeout_o = 1'b0;
`endif

    assign val_if.val_enable     = enable_q;
    assign val_if.val_tipo       = tipo_q;
    assign val_if.val_x1         = x_q;
    assign val_if.val_y1         = y_q;
    assign val_if.val_direcao    = direcao_q;
    assign val_if.val_orientacao = orientacao_q;
    assign val_if.val_jogador    = jogador_q;

    assign indice_navio_o   = indice_q;
    assign aceito_o         = aceito_q;
    assign erro_borda_o     = erro_borda_q;
    assign erro_memoria_o   = erro_memoria_q;
    assign ocupado_o        = ocupado_q;
    assign fase_concluida_o = concluida_q;

endmodule

// File: tb/tb_controlador_posicionamento.sv
// Testbench for controlador_posicionamento: random placements checked against a fleet-walk model.
// Watchdog scenario runs only when VALIDADOR_WATCHDOG_EN is defined.
module tb_controlador_posicionamento;

    localparam int NAVIOS  = 11;
    localparam int TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       iniciar;
    logic       confirma;
    logic [3:0] xIn;
    logic [3:0] yIn;
    logic       dirIn;
    logic [2:0] oriIn;
    logic [3:0] indice;
    logic       aceito;
    logic       erroBorda;
    logic       erroMemoria;
    logic       ocupado;
    logic       faseConcluida;
    logic       erroTimeout;

    int   nAsserts = 0;
    int   nFails   = 0;
    int   expIndice;
    logic expJogador;
    logic expFim;

    controlador_posicionamento_if valBus ();

    controlador_posicionamento dut (
        .clk              (clk),
        .rst              (rst),
        .iniciar_i        (iniciar),
        .confirma_i       (confirma),
        .x_i              (xIn),
        .y_i              (yIn),
        .direcao_i        (dirIn),
        .orientacao_i     (oriIn),
        .val_if           (valBus),
        .indice_navio_o   (indice),
        .aceito_o         (aceito),
        .erro_borda_o     (erroBorda),
        .erro_memoria_o   (erroMemoria),
        .ocupado_o        (ocupado),
        .fase_concluida_o (faseConcluida),
        .erro_timeout_o   (erroTimeout)
    );

    always #5 clk = ~clk;

    // Fleet composition as counts per type: 1, 2, 3, 5.
    function automatic int tipoEsperado(input int idx);
        int quantos[4] = '{1, 2, 3, 5};
        int acumulado = 0;
        for (int t = 0; t < 4; t++) begin
            acumulado += quantos[t];
            if (idx < acumulado) return t;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Called at a falling edge; holds the pulses for exactly one rising edge.
    task automatic applyStimulus(input logic ini, input logic conf);
        iniciar  = ini;
        confirma = conf;
        @(negedge clk);
        iniciar  = 1'b0;
        confirma = 1'b0;
    endtask

    task automatic placeShip(input logic conf, input logic [1:0] causa, input int stale, input logic lateConfirm);
        logic [3:0] px, py;
        logic       pd;
        logic [2:0] po;
        int         lat;
        logic       trocar;
        px = 4'($urandom_range(0, 9));
        py = 4'($urandom_range(0, 9));
        pd = 1'($urandom_range(0, 1));
        po = 3'($urandom_range(0, 7));
        xIn = px; yIn = py; dirIn = pd; oriIn = po;
        if (stale > 0) valBus.val_ready = 1'b1;
        checkOutput("tipoAtual", 32'(valBus.val_tipo), 32'(tipoEsperado(expIndice)));
        checkOutput("jogadorAtual", 32'(valBus.val_jogador), 32'(expJogador));
        applyStimulus(1'b0, 1'b1);
        checkOutput("enableEmLibera", 32'(valBus.val_enable), 0);
        checkOutput("x1", 32'(valBus.val_x1), 32'(px));
        checkOutput("y1", 32'(valBus.val_y1), 32'(py));
        checkOutput("direcao", 32'(valBus.val_direcao), 32'(pd));
        checkOutput("orientacao", 32'(valBus.val_orientacao), 32'(po));
        if (stale > 0) begin
            repeat (stale) begin
                @(negedge clk);
                checkOutput("enableReadyAntigo", 32'(valBus.val_enable), 0);
            end
            valBus.val_ready = 1'b0;
        end
        @(negedge clk);
        checkOutput("enableSobe", 32'(valBus.val_enable), 1);
        lat = lateConfirm ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
        repeat (lat) begin
            if (lateConfirm) begin
                xIn = 4'(px + 4'd1);
                confirma = 1'b1;
            end
            @(negedge clk);
            confirma = 1'b0;
            checkOutput("enableRetido", 32'(valBus.val_enable), 1);
        end
        valBus.val_ready           = 1'b1;
        valBus.val_conflito        = conf;
        valBus.val_conflitoBorda   = causa[0];
        valBus.val_conflitoMemoria = causa[1];
        @(negedge clk);
        valBus.val_ready           = 1'b0;
        valBus.val_conflito        = 1'b0;
        valBus.val_conflitoBorda   = 1'b0;
        valBus.val_conflitoMemoria = 1'b0;
        checkOutput("enableCai", 32'(valBus.val_enable), 0);
        @(negedge clk);
        checkOutput("aceito", 32'(aceito), 32'(!conf));
        checkOutput("erroBorda", 32'(erroBorda), 32'(conf & causa[0]));
        checkOutput("erroMemoria", 32'(erroMemoria), 32'(conf & causa[1]));
        checkOutput("x1Retido", 32'(valBus.val_x1), 32'(px));
        trocar = !conf && (expIndice == NAVIOS - 1);
        if (!conf && expIndice < NAVIOS - 1) expIndice++;
        checkOutput("indice", 32'(indice), 32'(expIndice));
        @(negedge clk);
        checkOutput("pulsosFim", {29'd0, aceito, erroBorda, erroMemoria}, 0);
        checkOutput("semTimeout", 32'(erroTimeout), 0);
        checkOutput("enableOcioso", 32'(valBus.val_enable), 0);
        if (trocar) begin
            if (!expJogador) begin
                expJogador = 1'b1;
                expIndice  = 0;
            end else begin
                expFim = 1'b1;
            end
        end
        checkOutput("indicePosTroca", 32'(indice), 32'(expIndice));
        checkOutput("jogador", 32'(valBus.val_jogador), 32'(expJogador));
        checkOutput("faseConcluida", 32'(faseConcluida), 32'(expFim));
        checkOutput("ocupado", 32'(ocupado), 32'(!expFim));
    endtask

    initial begin
        int   guard;
        logic feitoBorda;
        rst = 1'b1; iniciar = 1'b0; confirma = 1'b0;
        xIn = 4'd0; yIn = 4'd0; dirIn = 1'b0; oriIn = 3'd0;
        valBus.val_ready = 1'b0; valBus.val_conflito = 1'b0;
        valBus.val_conflitoBorda = 1'b0; valBus.val_conflitoMemoria = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("resetEnable", 32'(valBus.val_enable), 0);
        checkOutput("resetIndice", 32'(indice), 0);
        checkOutput("resetJogador", 32'(valBus.val_jogador), 0);
        checkOutput("resetTipo", 32'(valBus.val_tipo), 0);
        checkOutput("resetOcupado", 32'(ocupado), 0);
        checkOutput("resetFase", 32'(faseConcluida), 0);
        checkOutput("resetPulsos", {29'd0, aceito, erroBorda, erroMemoria}, 0);
        checkOutput("resetTimeout", 32'(erroTimeout), 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] confirma in idle, then iniciar with confirma together");
        applyStimulus(1'b0, 1'b1);
        @(negedge clk);
        checkOutput("ociosoIgnoraConfirma", {30'd0, ocupado, valBus.val_enable}, 0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("iniciarOcupado", 32'(ocupado), 1);
        @(negedge clk);
        checkOutput("confirmaDescartado", 32'(valBus.val_enable), 0);
        expIndice = 0; expJogador = 1'b0; expFim = 1'b0;

        $display("[TB] player 0, all ships accepted");
        for (int i = 0; i < NAVIOS; i++) placeShip(1'b0, 2'b00, 0, 1'b0);

        $display("[TB] player 1 with random rejections");
        guard = 0; feitoBorda = 1'b0;
        while (!expFim && guard < 60) begin
            guard++;
            if (expIndice == 3 && !feitoBorda) begin
                feitoBorda = 1'b1;
                placeShip(1'b1, 2'b01, 0, 1'b0);
                checkOutput("bordaIndice", 32'(indice), 3);
                checkOutput("bordaTipo", 32'(valBus.val_tipo), 2);
            end else if ($urandom_range(0, 3) == 0) begin
                placeShip(1'b1, 2'($urandom_range(1, 3)), 0, 1'b0);
            end else begin
                placeShip(1'b0, 2'b00, (expIndice == 5) ? 2 : 0, expIndice == 8);
            end
        end
        checkOutput("faseFinal", 32'(faseConcluida), 1);
        checkOutput("ocupadoFinal", 32'(ocupado), 0);
        applyStimulus(1'b0, 1'b1);
        @(negedge clk);
        checkOutput("concluidoIgnoraConfirma", {30'd0, faseConcluida, valBus.val_enable}, 2);

        $display("[TB] restart from concluded phase");
        applyStimulus(1'b1, 1'b0);
        checkOutput("reinicioFase", 32'(faseConcluida), 0);
        checkOutput("reinicioJogador", 32'(valBus.val_jogador), 0);
        checkOutput("reinicioIndice", 32'(indice), 0);
        checkOutput("reinicioOcupado", 32'(ocupado), 1);
        expIndice = 0; expJogador = 1'b0; expFim = 1'b0;
        for (int i = 0; i < NAVIOS; i++) begin
            if (i == 4) begin
                applyStimulus(1'b1, 1'b0);
                checkOutput("iniciarOcupadoIgnorado", 32'(indice), 4);
            end
            placeShip(1'b0, 2'b00, 0, 1'b0);
        end
        for (int i = 0; i < 7; i++) placeShip(1'b0, 2'b00, 0, 1'b0);

        $display("[TB] reset during validation of player 1 ship 7");
        checkOutput("navio7", 32'(indice), 7);
        applyStimulus(1'b0, 1'b1);
        @(negedge clk);
        checkOutput("enableAntesReset", 32'(valBus.val_enable), 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("resetAssincEnable", 32'(valBus.val_enable), 0);
        checkOutput("resetAssincIndice", 32'(indice), 0);
        checkOutput("resetAssincJogador", 32'(valBus.val_jogador), 0);
        checkOutput("resetAssincOcupado", 32'(ocupado), 0);
        checkOutput("resetAssincX1", {24'd0, valBus.val_x1, valBus.val_y1}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(1'b0, 1'b1);
        @(negedge clk);
        checkOutput("posResetOcioso", {30'd0, ocupado, valBus.val_enable}, 0);

`ifdef VALIDADOR_WATCHDOG_EN
        $display("[TB] validator never answers");
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        @(negedge clk);
        checkOutput("wdEnable", 32'(valBus.val_enable), 1);
        repeat (TIMEOUT - 1) @(negedge clk);
        checkOutput("wdAntes", {30'd0, erroTimeout, valBus.val_enable}, 1);
        @(negedge clk);
        checkOutput("wdExpira", {30'd0, erroTimeout, valBus.val_enable}, 2);
        checkOutput("wdIndice", 32'(indice), 0);
        @(negedge clk);
        checkOutput("wdPulso", 32'(erroTimeout), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
